// File: rtl/rs_encoder_255_251.sv
// Systematic RS(255,251) encoder over GF(2^8), poly 0x11D, t=2.
// Message symbols pass through with one cycle of latency, then four parity symbols follow.
module rs_encoder_255_251 #(
    parameter int NN   = 255,
    parameter int KK   = 251,
    parameter int NPAR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_val,
    input  logic       din_sop,
    input  logic       din_eop,
    input  logic [7:0] din,
    output logic       dout_val,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic [7:0] dout,
    output logic       busy
);

    localparam int CW = $clog2(NN);

    // Multiply by a constant in GF(2^8); the constant operand collapses this to XOR trees.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    logic [NPAR-1:0][7:0] r_par;
    logic [CW-1:0]        r_cnt;
    logic [1:0]           r_fcnt;

    logic [NPAR-1:0][7:0] w_prev;
    logic [NPAR-1:0][7:0] w_next;
    logic [7:0]           w_fb;
    logic [CW-1:0]        w_cnt;
    logic                 w_end;

    // A sop restarts from zero state, dropping whatever block was in flight.
    always_comb begin
        w_prev    = din_sop ? '0 : r_par;
        w_fb      = din ^ w_prev[3];
        w_next[3] = w_prev[2] ^ gf_mul(w_fb, 8'h0F);
        w_next[2] = w_prev[1] ^ gf_mul(w_fb, 8'h36);
        w_next[1] = w_prev[0] ^ gf_mul(w_fb, 8'h78);
        w_next[0] = gf_mul(w_fb, 8'h40);
        w_cnt     = (din_sop ? '0 : r_cnt) + 1'b1;
        w_end     = din_eop | (w_cnt == CW'(KK));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_val <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout     <= 8'h00;
            busy     <= 1'b0;
            r_par    <= '0;
            r_cnt    <= '0;
            r_fcnt   <= '0;
        end else begin
            dout_val <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout     <= 8'h00;
            if (busy) begin
                // Flush shifts parity out highest degree first; zero-fill leaves the LFSR clear.
                dout_val <= 1'b1;
                dout     <= r_par[NPAR-1];
                r_par    <= {r_par[NPAR-2:0], 8'h00};
                r_fcnt   <= r_fcnt + 2'd1;
                if (r_fcnt == 2'(NPAR - 1)) begin
                    busy     <= 1'b0;
                    dout_eop <= 1'b1;
                end
            end else if (din_val) begin
                dout_val <= 1'b1;
                dout_sop <= din_sop;
                dout     <= din;
                r_par    <= w_next;
                if (w_end) begin
                    busy   <= 1'b1;
                    r_cnt  <= '0;
                    r_fcnt <= '0;
                end else begin
                    r_cnt <= w_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_encoder_255_251.sv
// Bench for rs_encoder_255_251: cycle model driven by polynomial long division,
// plus syndrome checks on every completed codeword.
module tb_rs_encoder_255_251;

    typedef logic [7:0] sym_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din_val = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    sym_t din = 8'h00;
    logic dout_val, dout_sop, dout_eop, busy;
    sym_t dout;

    rs_encoder_255_251 dut (
        .clk(clk), .rst_n(rst_n),
        .din_val(din_val), .din_sop(din_sop), .din_eop(din_eop), .din(din),
        .dout_val(dout_val), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout(dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    sym_t exp_t [256];
    int   log_t [256];

    function automatic sym_t gmul(input sym_t a, input sym_t b);
        if (a == 0 || b == 0) return 8'h00;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    sym_t gen [4];
    sym_t msg [$];
    sym_t par [4];
    sym_t cw  [$];
    sym_t obs [$];
    int   busy_left = 0;
    int   n_eop = 0;
    int   run = 0, max_run = 0;
    logic e_val, e_sop, e_eop, e_busy;
    sym_t e_dout;

    // Remainder of m(x)*x^4 divided by g(x), by schoolbook long division.
    function automatic void calc_parity();
        sym_t w [$];
        sym_t c;
        int   len;
        w   = msg;
        len = msg.size();
        for (int i = 0; i < 4; i++) w.push_back(8'h00);
        for (int i = 0; i < len; i++) begin
            c = w[i];
            for (int j = 0; j < 4; j++) w[i+1+j] = w[i+1+j] ^ gmul(c, gen[j]);
        end
        for (int j = 0; j < 4; j++) par[j] = w[len+j];
    endfunction

    task automatic check_syndromes();
        sym_t s;
        for (int k = 0; k < 4; k++) begin
            s = 8'h00;
            foreach (cw[i]) s = gmul(s, exp_t[k]) ^ cw[i];
            chk($sformatf("syndrome%0d", k), s, 0);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic s, input logic e, input sym_t d);
        rst_n = ~r; din_val = v; din_sop = s; din_eop = e; din = d;
        {e_val, e_sop, e_eop, e_dout} = '0;
        if (r) begin
            msg.delete();
            busy_left = 0;
        end else if (busy_left > 0) begin
            e_val  = 1'b1;
            e_dout = par[4-busy_left];
            e_eop  = (busy_left == 1);
            busy_left--;
        end else if (v) begin
            if (s) msg.delete();
            msg.push_back(d);
            e_val  = 1'b1;
            e_sop  = s;
            e_dout = d;
            if (e || msg.size() == 251) begin
                calc_parity();
                msg.delete();
                busy_left = 4;
            end
        end
        e_busy = (busy_left > 0);
        @(posedge clk); #1;
        chk("outputs{val,sop,eop,busy,dout}", {dout_val, dout_sop, dout_eop, busy, dout},
            {e_val, e_sop, e_eop, e_busy, e_dout});
        if (r) cw.delete();
        if (dout_val) begin
            obs.push_back(dout);
            if (dout_sop) cw.delete();
            cw.push_back(dout);
            if (dout_eop) begin
                check_syndromes();
                cw.delete();
                n_eop++;
            end
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic expect_single(input string tag, input sym_t d);
        chk({tag, "_len"}, obs.size(), 5);
        if (obs.size() == 5) begin
            chk({tag, "_data"}, obs[0], d);
            for (int j = 0; j < 4; j++) chk($sformatf("%s_par%0d", tag, j), obs[j+1], gmul(d, gen[j]));
        end
    endtask

    sym_t ref_par [4];
    sym_t g01 [5];

    initial begin
        logic [8:0] x;
        int i;
        x = 9'h001;
        for (int k = 0; k < 255; k++) begin
            exp_t[k] = x[7:0];
            log_t[x[7:0]] = k;
            x = {x[7:0], 1'b0};
            if (x[8]) x = x ^ 9'h11D;
        end
        gen = '{8'h0F, 8'h36, 8'h78, 8'h40};
        g01 = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};

        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // single-symbol block of 0x01 yields the generator coefficients
        obs.delete();
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h01);
        idle(6);
        chk("one_len", obs.size(), 5);
        if (obs.size() == 5) for (int j = 0; j < 5; j++) chk($sformatf("one_sym%0d", j), obs[j], g01[j]);

        obs.delete();
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        idle(6);
        expect_single("zero", 8'h00);

        // full-length block, continuous
        obs.delete(); n_eop = 0;
        for (int k = 0; k < 251; k++) step(1'b0, 1'b1, k == 0, k == 250, 8'(251 - k));
        idle(6);
        chk("full_len", obs.size(), 255);
        chk("full_eops", n_eop, 1);
        if (obs.size() == 255) for (int j = 0; j < 4; j++) ref_par[j] = obs[251+j];

        // same block with gaps and traffic while busy
        obs.delete(); n_eop = 0; i = 0;
        while (i < 251) begin
            if ($urandom_range(3) == 0) step(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));
            else begin
                step(1'b0, 1'b1, i == 0, i == 250, 8'(251 - i));
                i++;
            end
        end
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom));
        idle(3);
        chk("gap_len", obs.size(), 255);
        chk("gap_eops", n_eop, 1);
        if (obs.size() == 255) for (int j = 0; j < 4; j++) chk($sformatf("gap_par%0d", j), obs[251+j], ref_par[j]);

        // reset in the middle of parity output
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h11);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h22);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        obs.delete();
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h01);
        idle(6);
        expect_single("post_rst", 8'h01);

        // back-to-back codewords; sop/eop while busy must be ignored
        obs.delete(); run = 0; max_run = 0;
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h01);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b1, 8'hAA);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
        idle(6);
        chk("b2b_run", max_run, 10);
        chk("b2b_len", obs.size(), 10);
        if (obs.size() == 10) begin
            for (int j = 0; j < 5; j++) chk($sformatf("b2b_a%0d", j), obs[j], g01[j]);
            chk("b2b_b_data", obs[5], 8'h55);
            for (int j = 0; j < 4; j++) chk($sformatf("b2b_b_par%0d", j), obs[6+j], gmul(8'h55, gen[j]));
        end

        // implicit end at 251 symbols, then sop-less symbols from zero state
        for (int k = 0; k < 260; k++) step(1'b0, 1'b1, k == 0, 1'b0, 8'($urandom));
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'($urandom));
        idle(6);

        // random traffic: gaps, aborts via sop, sop-less starts, rare resets
        repeat (3000) step($urandom_range(199) == 0, $urandom_range(3) != 0,
                           $urandom_range(15) == 0, $urandom_range(15) == 0, 8'($urandom));
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rs_encoder_255_251.md
RS_ENCODER_255_251 -- requirements
Module: rs_encoder_255_251

Interface
REQ-001 Parameters (fixed; other values unsupported):
- NN, 255, codeword length in symbols.
- KK, 251, maximum message length in symbols.
- NPAR, 4, parity symbols (t = 2).

REQ-002 Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- din_val  in  1  input symbol valid.
- din_sop  in  1  first message symbol; qualified by din_val.
- din_eop  in  1  last message symbol; qualified by din_val.
- din  in  8  message symbol.
- dout_val  out  1  output symbol valid (data or parity).
- dout_sop  out  1  first codeword symbol.
- dout_eop  out  1  last parity symbol.
- dout  out  8  output symbol.
- busy  out  1  encoder is flushing parity; input is ignored.

Function
REQ-003 The block SHALL be a systematic RS encoder over GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
REQ-004 The generator SHALL be g(x) = (x+a^0)(x+a^1)(x+a^2)(x+a^3) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40.
REQ-005 An input symbol SHALL be accepted when din_val=1 and busy=0; a symbol presented while busy=1 SHALL be ignored.
REQ-006 Each accepted symbol SHALL update a 4-register LFSR r3..r0:
- fb = din XOR r3;
- r3 <= r2 ^ fb*0x0F; r2 <= r1 ^ fb*0x36; r1 <= r0 ^ fb*0x78; r0 <= fb*0x40.
REQ-007 An accepted symbol with din_sop=1 SHALL use r3..r0 = 0 as the prior state, including when a block is already in progress (the old block is abandoned, no parity emitted).
REQ-008 An accepted symbol SHALL appear on dout exactly 1 cycle later with dout_val=1 and dout_sop equal to its din_sop; dout_eop=0.
REQ-009 Gaps are allowed: in a cycle with no accepted input and no parity output, dout_val/dout_sop/dout_eop SHALL be 0 and LFSR state SHALL hold.
REQ-010 A block SHALL end on an accepted symbol with din_eop=1, or implicitly on the 251st accepted symbol since the last sop. Shorter blocks (shortened codes, 1..251 symbols) SHALL be encoded with the same LFSR.
REQ-011 sop and eop together SHALL form a 1-symbol block.
REQ-012 If the block ends at cycle T:
- busy=1 for cycles T+1..T+4;
- T+1: dout = last data symbol;
- T+2..T+5: dout = parity r3, r2, r1, r0 (highest degree first), dout_val=1;
- dout_eop=1 at T+5 only.
REQ-013 A symbol accepted at T+5 SHALL be output at T+6, giving back-to-back codewords without gaps.
REQ-014 Symbols accepted without a preceding sop since reset or the last block end SHALL be encoded from zero LFSR state.
REQ-015 All outputs SHALL be registered; combinational paths from din to dout are not permitted.

Reset
REQ-016 While rst_n=0 at a clock edge: dout_val, dout_sop, dout_eop, busy, dout, r3..r0 and the symbol counter SHALL clear to 0.
REQ-017 Reset mid-block or mid-parity SHALL abort the block; no further parity output.
REQ-018 The first edge with rst_n=1 SHALL accept input.

Verification
REQ-019 1-symbol block (sop+eop, din=0x01) -> dout = 0x01, 0x0F, 0x36, 0x78, 0x40 on consecutive cycles; sop on the first, eop on the last; busy high 4 cycles.
REQ-020 1-symbol block, din=0x00 -> dout 0x00 then 4 parity 0x00; eop on the 5th output.
REQ-021 251 symbols 0xFB down to 0x01, continuous, sop on first, eop on last -> 255 outputs; first 251 equal input; codeword polynomial evaluates to 0 at a^0..a^3 (reference model); dout_eop exactly once.
REQ-022 Same block with a random din_val gaps and din_val asserted during busy -> parity identical to REQ-021; symbols during busy dropped.
REQ-023 rst_n=0 during parity output -> all outputs 0 next cycle; a following 1-symbol block with 0x01 -> REQ-019 values.
REQ-024 Two back-to-back 1-symbol blocks (second sop at T+5) -> 10 contiguous dout_val cycles; both parity sets correct.
